// File: rtl/instruction_pkg.sv
// ---------------------------------------------------------------------------
// instruction_pkg
//
// Shared definitions for the random instruction-memory loader:
//   - instr_type_e : 2-bit type code taken from the LFSR low bits
//                    (0 means "no instruction this cycle")
//   - opcode / funct constants for the small MIPS-like subset we emit
//   - FUNCT_TBL    : R-type funct selected by lfsr[4:2]
//   - OPC_TBL      : I-type opcode selected by lfsr[3:2]
//   - LFSR constants used by lfsr32
//   - type_enabled : applies the type mask (an all-zero mask enables all)
// ---------------------------------------------------------------------------
package instruction_pkg;

  typedef enum logic [1:0] {
    R_type = 2'd1,
    I_type = 2'd2,
    J_type = 2'd3
  } instr_type_e;

  // Opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Element 0 is the first entry listed.
  localparam logic [5:0] FUNCT_TBL [8] = '{
    FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR,
    FUNCT_SLT, FUNCT_ADD, FUNCT_SUB, FUNCT_OR
  };

  localparam logic [5:0] OPC_TBL [4] = '{
    OPC_LW, OPC_SW, OPC_BEQ, OPC_ADDI
  };

  // Galois feedback taps (x^32 + x^22 + x^2 + x + 1) and the reset state.
  localparam logic [31:0] LFSR_POLY  = 32'h80200003;
  localparam logic [31:0] LFSR_RESET = 32'h00000001;

  // True when type code t is allowed by the mask. A zero mask would stall
  // generation forever, so it is treated as "all types enabled".
  function automatic logic type_enabled(logic [1:0] t, logic [2:0] mask);
    logic [2:0] m;
    m = (mask == 3'b000) ? 3'b111 : mask;
    case (t)
      R_type:  return m[0];
      I_type:  return m[1];
      J_type:  return m[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr32.sv
// ---------------------------------------------------------------------------
// lfsr32
//
// 32-bit right-shifting Galois LFSR.
//   clk       : rising-edge clock
//   rst       : async active-high reset, state returns to 32'h1
//   load      : load load_val this edge (has priority over step)
//   load_val  : value to load; caller guarantees it is non-zero
//   step      : advance one position this edge
//   lfsr_out  : current state
// ---------------------------------------------------------------------------
module lfsr32
  import instruction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] lfsr_out
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // The bit shifted out of the bottom folds back in through the taps.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = {1'b0, state_q[31:1]} ^ ({32{state_q[0]}} & LFSR_POLY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LFSR_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign lfsr_out = state_q;

endmodule

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//
// Fills an instruction memory with pseudo-random R/I/J words from an LFSR,
// then releases the CPU under test from reset for a fixed number of cycles.
//
//   clk, rst    : clock and async active-high reset
//   start       : one-cycle request, accepted only in IDLE or DONE
//   seed        : LFSR seed captured on an accepted start (0 becomes 1)
//   type_mask   : enabled types, bit0 R / bit1 I / bit2 J (0 = all)
//   imem_addr   : CPU fetch word address
//   imem_rdata  : fetched word, 0 (NOP) beyond what has been written
//   cpu_rst     : reset to the CPU, low only while running
//   busy, done  : sequence status
//   load_count  : words written in the current sequence
// ---------------------------------------------------------------------------
module instr_mem_loader
  import instruction_pkg::*;
#(
  parameter  int DEPTH      = 1024,
  parameter  int NUM_INSTR  = 10,
  parameter  int RUN_CYCLES = 20,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       seed,
  input  logic [2:0]        type_mask,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_rdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   load_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int RUN_W = $clog2(RUN_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GEN  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] load_count_q, load_count_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;

  logic [31:0]       lfsr;
  logic [1:0]        type_code;
  logic              start_accept;
  logic              wr_en;
  logic [31:0]       wr_word;
  logic [31:0]       seed_eff;
  logic [5:0]        unused_lfsr_hi;

  logic [31:0] mem [DEPTH];

  // An all-zero seed would lock the LFSR at zero.
  assign seed_eff  = (seed == 32'h0) ? LFSR_RESET : seed;
  assign type_code = lfsr[1:0];
  assign unused_lfsr_hi = lfsr[31:26];

  lfsr32 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_accept),
    .load_val (seed_eff),
    .step     (state_q == ST_GEN),
    .lfsr_out (lfsr)
  );

  // Sequencer. Every GEN cycle consumes one LFSR value; the value becomes a
  // word only if its type code is non-zero and enabled by the mask.
  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    run_cnt_d    = run_cnt_q;
    start_accept = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_accept = 1'b1;
          load_count_d = '0;
          state_d      = ST_GEN;
        end
      end
      ST_GEN: begin
        if (type_enabled(type_code, type_mask)) begin
          wr_en        = 1'b1;
          load_count_d = load_count_q + 1'b1;
          if (load_count_q == CNT_W'(NUM_INSTR - 1)) begin
            run_cnt_d = '0;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (run_cnt_q == RUN_W'(RUN_CYCLES - 1)) begin
          state_d = ST_DONE;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word formation from the current LFSR value.
  always_comb begin
    wr_word = 32'h0;
    case (type_code)
      R_type:  wr_word = {OPC_RTYPE, lfsr[25:21], lfsr[20:16], lfsr[15:11],
                          5'd0, FUNCT_TBL[lfsr[4:2]]};
      I_type:  wr_word = {OPC_TBL[lfsr[3:2]], lfsr[25:0]};
      J_type:  wr_word = {OPC_J, 26'(lfsr[ADDR_W-1:0])};
      default: wr_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      load_count_q <= '0;
      run_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      run_cnt_q    <= run_cnt_d;
    end
  end

  // Memory is deliberately never cleared; the read mux hides stale words.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[load_count_q[ADDR_W-1:0]] <= wr_word;
    end
  end

  assign imem_rdata = (CNT_W'(imem_addr) < load_count_q) ? mem[imem_addr] : 32'h0;

  assign cpu_rst    = (state_q != ST_RUN);
  assign busy       = (state_q == ST_GEN) || (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign load_count = load_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Directed bench for instr_mem_loader. A small reference model computes the
// expected word sequence and the number of GEN cycles for a seed/mask, and
// each run is checked for timing, status and memory contents.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

  localparam int DEPTH      = 1024;
  localparam int NUM_INSTR  = 10;
  localparam int RUN_CYCLES = 20;
  localparam int ADDR_W     = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       seed = 32'h0;
  logic [2:0]        type_mask = 3'b000;
  logic [ADDR_W-1:0] imem_addr = '0;
  logic [31:0]       imem_rdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   load_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_words [NUM_INSTR];
  int          exp_steps;

  instr_mem_loader #(
    .DEPTH      (DEPTH),
    .NUM_INSTR  (NUM_INSTR),
    .RUN_CYCLES (RUN_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .type_mask  (type_mask),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .load_count (load_count)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: count it, and report tag/observed/expected on mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference LFSR step, written out from the polynomial definition
  function automatic logic [31:0] modelNext(input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ 32'h80200003;
    else      return s >> 1;
  endfunction

  function automatic logic [5:0] modelFunct(input logic [2:0] idx);
    case (idx)
      3'd0: return 6'h20;
      3'd1: return 6'h22;
      3'd2: return 6'h24;
      3'd3: return 6'h25;
      3'd4: return 6'h2A;
      3'd5: return 6'h20;
      3'd6: return 6'h22;
      default: return 6'h25;
    endcase
  endfunction

  function automatic logic [5:0] modelOpc(input logic [1:0] idx);
    case (idx)
      2'd0: return 6'h23;
      2'd1: return 6'h2B;
      2'd2: return 6'h04;
      default: return 6'h08;
    endcase
  endfunction

  function automatic logic [31:0] modelWord(input logic [31:0] l);
    case (l[1:0])
      2'd1: return {6'h00, l[25:21], l[20:16], l[15:11], 5'h00, modelFunct(l[4:2])};
      2'd2: return {modelOpc(l[3:2]), l[25:0]};
      2'd3: return {6'h02, 16'h0000, l[9:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Fill exp_words/exp_steps for a (non-zero) starting LFSR value and mask
  task automatic buildExpected(input logic [31:0] s0, input logic [2:0] mask);
    logic [31:0] s;
    logic [2:0]  m;
    int          n;
    s = s0;
    m = (mask == 3'b000) ? 3'b111 : mask;
    n = 0;
    exp_steps = 0;
    while (n < NUM_INSTR && exp_steps < 10000) begin
      if (s[1:0] != 2'd0 && m[int'(s[1:0]) - 1]) begin
        exp_words[n] = modelWord(s);
        n++;
      end
      exp_steps++;
      s = modelNext(s);
    end
  endtask

  // Launch a sequence and check its timing; optionally pulse start during
  // GEN and RUN (with a different seed) to show it is ignored there.
  task automatic applyStimulus(input string tag, input logic [31:0] s,
                               input logic [2:0] mask, input bit glitch);
    int gen;
    int run;
    seed      = s;
    type_mask = mask;
    start     = 1'b1;
    tick();
    start = 1'b0;
    seed  = 32'hFFFF_0000;
    checkOutput({tag, " load_count after start"}, 32'(load_count), 32'd0);
    checkOutput({tag, " busy in GEN"}, 32'(busy), 32'd1);
    gen = 0;
    while (cpu_rst && gen < 1000) begin
      if (glitch && gen == 1) start = 1'b1;
      tick();
      start = 1'b0;
      gen++;
    end
    checkOutput({tag, " GEN cycles"}, 32'(gen), 32'(exp_steps));
    run = 0;
    while (!cpu_rst && run < 1000) begin
      if (glitch && run == 3) start = 1'b1;
      tick();
      start = 1'b0;
      run++;
    end
    checkOutput({tag, " RUN cycles"}, 32'(run), 32'(RUN_CYCLES));
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " busy after"}, 32'(busy), 32'd0);
    checkOutput({tag, " cpu_rst after"}, 32'(cpu_rst), 32'd1);
    checkOutput({tag, " load_count final"}, 32'(load_count), 32'(NUM_INSTR));
  endtask

  // Compare every written word with the model plus the first unwritten slot
  task automatic verifyWords(input string tag);
    for (int i = 0; i < NUM_INSTR; i++) begin
      imem_addr = ADDR_W'(i);
      #1;
      checkOutput($sformatf("%s word%0d", tag, i), imem_rdata, exp_words[i]);
    end
    imem_addr = ADDR_W'(NUM_INSTR);
    #1;
    checkOutput({tag, " past end"}, imem_rdata, 32'h0);
  endtask

  // Directed sequence of scenarios
  initial begin
    int k;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset load_count", 32'(load_count), 32'd0);
    imem_addr = ADDR_W'(0);
    #1;
    checkOutput("reset rdata@0", imem_rdata, 32'h0);
    imem_addr = ADDR_W'(5);
    #1;
    checkOutput("reset rdata@5", imem_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // R-only run from seed 1; the first word is add $0,$0,$0
    buildExpected(32'h1, 3'b001);
    checkOutput("model first R word", exp_words[0], 32'h0000_0020);
    applyStimulus("R-only", 32'h1, 3'b001, 1'b0);
    verifyWords("R-only");
    tick();
    tick();
    tick();
    checkOutput("done holds", 32'(done), 32'd1);

    // J-only run, with start pulses during GEN and RUN
    buildExpected(32'h1234_5678, 3'b100);
    applyStimulus("J-only", 32'h1234_5678, 3'b100, 1'b1);
    verifyWords("J-only");
    imem_addr = ADDR_W'(3);
    #1;
    checkOutput("J-only opcode", 32'(imem_rdata[31:26]), 32'h02);

    // Zero mask behaves as all types enabled
    buildExpected(32'hDEAD_BEEF, 3'b000);
    applyStimulus("all-types", 32'hDEAD_BEEF, 3'b000, 1'b0);
    verifyWords("all-types");

    // Reset after four writes, start held during reset, then a clean rerun
    buildExpected(32'hC0FF_EE11, 3'b111);
    seed      = 32'hC0FF_EE11;
    type_mask = 3'b111;
    start     = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (load_count != (ADDR_W+1)'(4) && k < 500) begin
      tick();
      k++;
    end
    checkOutput("midreset reached 4", 32'(load_count), 32'd4);
    rst = 1'b1;
    #1;
    checkOutput("midreset cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset load_count", 32'(load_count), 32'd0);
    start = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("start ignored in reset", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      imem_addr = ADDR_W'(i);
      #1;
      checkOutput($sformatf("midreset masked@%0d", i), imem_rdata, 32'h0);
    end
    applyStimulus("rerun", 32'hC0FF_EE11, 3'b111, 1'b0);
    verifyWords("rerun");

    // Seed 0 must reproduce the seed 1 sequence
    buildExpected(32'h1, 3'b011);
    applyStimulus("seed0", 32'h0, 3'b011, 1'b0);
    verifyWords("seed0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
